// File: rtl/scratchpad_port_arbiter_pkg.sv
// Shared constants and helpers for the scratchpad port arbiter and its round-robin sub-arbiters.
package scratchpad_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int MAX_REQ            = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scratchpad_port_arbiter_if.sv
// Requester-side and SRAM-side bus of the scratchpad port arbiter. The master modport is the
// environment (requesters plus SRAM), and the slave modport is the arbiter.
interface scratchpad_port_arbiter_if
    import scratchpad_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          sram_we_a;
    logic [ADDR_WIDTH-1:0]         sram_addr_a;
    logic [DATA_WIDTH-1:0]         sram_wdata_a;
    logic                          sram_re_b;
    logic [ADDR_WIDTH-1:0]         sram_addr_b;
    logic [DATA_WIDTH-1:0]         sram_rdata_b;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, sram_rdata_b,
        input  req_ready, rsp_valid, rsp_rdata,
        input  sram_we_a, sram_addr_a, sram_wdata_a, sram_re_b, sram_addr_b
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, sram_rdata_b,
        output req_ready, rsp_valid, rsp_rdata,
        output sram_we_a, sram_addr_a, sram_wdata_a, sram_re_b, sram_addr_b
    );

endinterface

// File: rtl/scratchpad_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at ptr. The pointer moves past
// the winner only when advance is high.
module rr_arbiter
    import scratchpad_pkg::*;
#(
    parameter int N = 2
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_idx;
    logic          found;

    always_comb begin
        logic [PW:0] pos;
        pos     = '0;
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N works.
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_q} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            if (!found && req[pos[PW-1:0]]) begin
                found               = 1'b1;
                gnt[pos[PW-1:0]]    = 1'b1;
                win_idx             = pos[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scratchpad_port_arbiter.sv
// Shares a write port A / registered-read port B scratchpad among NUM_REQ requesters with
// independent write and read round-robin arbiters and a same-address write/read hazard stall.
module scratchpad_port_arbiter
    import scratchpad_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REQ    = 2
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    scratchpad_port_arbiter_if.slave  bus
);
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic [NUM_REQ-1:0] wr_req;
    logic [NUM_REQ-1:0] rd_req;
    logic [NUM_REQ-1:0] wr_cand;
    logic [NUM_REQ-1:0] rd_cand;
    logic [NUM_REQ-1:0] wr_gnt;
    logic [NUM_REQ-1:0] rd_gnt;
    logic               hazard;
    logic               rd_advance;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_cand_addr;

    logic [NUM_REQ-1:0] rd_owner_q;
    logic [NUM_REQ-1:0] rd_owner_d;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wr_req[gi]    = bus.req_valid[gi] &  bus.req_we[gi];
            assign rd_req[gi]    = bus.req_valid[gi] & ~bus.req_we[gi];
        end
    endgenerate

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wr_req),
        .advance (rst_n),
        .gnt     (wr_cand)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rd_req),
        .advance (rd_advance),
        .gnt     (rd_cand)
    );

    assign wr_gnt = wr_cand & {NUM_REQ{rst_n}};

    // One-hot AND-OR muxes; an empty grant vector yields zero.
    always_comb begin
        wr_addr      = '0;
        wr_data      = '0;
        rd_cand_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                wr_addr = wr_addr | addr_arr[i];
                wr_data = wr_data | wdata_arr[i];
            end
            if (rd_cand[i]) begin
                rd_cand_addr = rd_cand_addr | addr_arr[i];
            end
        end
    end

    // A read of the address being written this cycle waits one cycle so it sees the new data.
    assign hazard     = (|wr_gnt) & (|rd_cand) & (wr_addr == rd_cand_addr);
    assign rd_gnt     = (hazard || !rst_n) ? '0 : rd_cand;
    assign rd_advance = rst_n & ~hazard;
    assign rd_owner_d = rd_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner_q <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.req_ready    = wr_gnt | rd_gnt;
    assign bus.sram_we_a    = |wr_gnt;
    assign bus.sram_addr_a  = wr_addr;
    assign bus.sram_wdata_a = wr_data;
    assign bus.sram_re_b    = |rd_gnt;
    assign bus.sram_addr_b  = (|rd_gnt) ? rd_cand_addr : '0;
    // A response still in flight when reset asserts is dropped, not delivered.
    assign bus.rsp_valid    = rd_owner_q & {NUM_REQ{rst_n}};
    assign bus.rsp_rdata    = bus.sram_rdata_b;

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Self-checking bench for scratchpad_port_arbiter: SRAM model, reference memory and a
// response scoreboard filled when reads are expected to be granted.
module tb_scratchpad_port_arbiter;
    import scratchpad_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int N  = 2;

    typedef struct {
        logic [N-1:0]  owner;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scratchpad_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) bus ();

    scratchpad_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [N-1:0]  v_s;
    logic [N-1:0]  we_s;
    logic [AW-1:0] a_s [N];
    logic [DW-1:0] d_s [N];

    logic [DW-1:0] sram_mem [int];
    logic [DW-1:0] ref_mem  [int];
    exp_t          sb [$];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    endfunction

    // Scratchpad model: registered read, write lands at the clock edge.
    always @(posedge clk) begin
        if (bus.sram_re_b) begin
            bus.sram_rdata_b <= sram_mem.exists(int'(bus.sram_addr_b)) ?
                                sram_mem[int'(bus.sram_addr_b)] : pat(bus.sram_addr_b);
        end
        if (bus.sram_we_a) begin
            sram_mem[int'(bus.sram_addr_a)] = bus.sram_wdata_a;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        v_s = v;  we_s = we;
        a_s[0] = a0; a_s[1] = a1;
        d_s[0] = d0; d_s[1] = d1;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
    endtask

    task automatic idle();
        drive('0, '0, '0, '0, '0, '0);
    endtask

    // One cycle: check the response due now, then this cycle's grants against exp_rdy.
    task automatic tick(input logic [N-1:0] exp_rdy);
        logic [N-1:0]  wr_w;
        logic [N-1:0]  rd_w;
        logic [AW-1:0] ea_a;
        logic [AW-1:0] ea_b;
        logic [DW-1:0] ed_a;
        exp_t          e;
        @(negedge clk);
        if (!rst_n) sb.delete();
        if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            e = sb.pop_front();
            check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(e.owner));
            check_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
        end else begin
            check_eq("rsp_idle", 64'(bus.rsp_valid), 64'(0));
        end
        wr_w = exp_rdy & v_s & we_s;
        rd_w = exp_rdy & v_s & ~we_s;
        ea_a = '0; ea_b = '0; ed_a = '0;
        for (int i = 0; i < N; i++) begin
            if (wr_w[i]) begin ea_a = a_s[i]; ed_a = d_s[i]; end
            if (rd_w[i]) ea_b = a_s[i];
        end
        $display("cyc=%0d rst_n=%b valid=%b we=%b ready=%b we_a=%b re_b=%b rsp_valid=%b rdata=%h",
                 cyc, rst_n, v_s, we_s, bus.req_ready, bus.sram_we_a, bus.sram_re_b,
                 bus.rsp_valid, bus.rsp_rdata);
        check_eq("req_ready",    64'(bus.req_ready),    64'(exp_rdy));
        check_eq("sram_we_a",    64'(bus.sram_we_a),    64'(|wr_w));
        check_eq("sram_addr_a",  64'(bus.sram_addr_a),  64'(ea_a));
        check_eq("sram_wdata_a", 64'(bus.sram_wdata_a), 64'(ed_a));
        check_eq("sram_re_b",    64'(bus.sram_re_b),    64'(|rd_w));
        check_eq("sram_addr_b",  64'(bus.sram_addr_b),  64'(ea_b));
        if (|wr_w) ref_mem[int'(ea_a)] = ed_a;
        if (|rd_w) begin
            e.owner = rd_w;
            e.data  = ref_rd(ea_b);
            e.cyc   = cyc;
            sb.push_back(e);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with every requester asserting.
        rst_n = 1'b0;
        drive(2'b11, 2'b01, 10'h005, 10'h006, 32'h1, 32'h2);
        repeat (3) tick(2'b00);
        rst_n = 1'b1;
        idle();
        tick(2'b00);

        // Write then read of the same word from the other requester.
        drive(2'b01, 2'b01, 10'h005, 10'h000, 32'hDEAD_BEEF, 32'h0);
        tick(2'b01);
        drive(2'b10, 2'b00, 10'h000, 10'h005, 32'h0, 32'h0);
        tick(2'b10);
        idle();
        tick(2'b00);

        // Back-to-back contended reads alternate 0,1,0,1,...
        drive(2'b11, 2'b00, 10'h010, 10'h020, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) tick((i % 2 == 0) ? 2'b01 : 2'b10);
        idle();
        tick(2'b00);

        // Concurrent write and read on different addresses.
        drive(2'b11, 2'b01, 10'h030, 10'h040, 32'h0000_0111, 32'h0);
        tick(2'b11);
        idle();
        tick(2'b00);

        // Same-address hazard: read stalls one cycle and returns the new data.
        drive(2'b11, 2'b01, 10'h07F, 10'h07F, 32'hA5A5_A5A5, 32'h0);
        tick(2'b01);
        drive(2'b10, 2'b00, 10'h000, 10'h07F, 32'h0, 32'h0);
        tick(2'b10);
        idle();
        tick(2'b00);

        // Contended writes: write pointer sits at 1 after three req0 writes.
        drive(2'b11, 2'b11, 10'h100, 10'h101, 32'h1111_0100, 32'h2222_0101);
        tick(2'b10);
        drive(2'b01, 2'b01, 10'h100, 10'h000, 32'h1111_0100, 32'h0);
        tick(2'b01);
        drive(2'b11, 2'b00, 10'h100, 10'h101, 32'h0, 32'h0);
        tick(2'b01);
        drive(2'b10, 2'b00, 10'h000, 10'h101, 32'h0, 32'h0);
        tick(2'b10);
        idle();
        tick(2'b00);

        // Reset right after a read grant: response dropped, both pointers back to 0.
        drive(2'b01, 2'b00, 10'h010, 10'h000, 32'h0, 32'h0);
        tick(2'b01);
        rst_n = 1'b0;
        idle();
        tick(2'b00);
        rst_n = 1'b1;
        tick(2'b00);
        drive(2'b11, 2'b00, 10'h100, 10'h101, 32'h0, 32'h0);
        tick(2'b01);
        drive(2'b10, 2'b00, 10'h000, 10'h101, 32'h0, 32'h0);
        tick(2'b10);
        drive(2'b11, 2'b11, 10'h300, 10'h301, 32'h3333_0300, 32'h4444_0301);
        tick(2'b01);
        drive(2'b10, 2'b10, 10'h000, 10'h301, 32'h0, 32'h4444_0301);
        tick(2'b10);
        drive(2'b11, 2'b00, 10'h300, 10'h301, 32'h0, 32'h0);
        tick(2'b01);
        drive(2'b10, 2'b00, 10'h000, 10'h301, 32'h0, 32'h0);
        tick(2'b10);
        idle();
        tick(2'b00);
        tick(2'b00);

        check_eq("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scratchpad_port_arbiter.md
# scratchpad_port_arbiter

Shares the dual-port SRAM scratchpad (one write port A, one registered-read port B) among `NUM_REQ` requesters. Two independent round-robin arbiters run side by side: one grants writes, one grants reads, so one write and one read can complete per cycle. A same-address write/read hazard check makes every read return data no older than any write granted in the same or an earlier cycle. Read data is routed back to the requester that issued the read. The block sits directly between the compute/DMA requesters and the scratchpad instance.

## Interface
Parameters:
- `DATA_WIDTH`, 32, scratchpad word width
- `ADDR_WIDTH`, 10, scratchpad address width
- `NUM_REQ`, 2, number of requesters (2..8)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset: synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same slicing
- `req_ready`  out  NUM_REQ  one-hot-per-port grant; request accepted when valid & ready
- `rsp_valid`  out  NUM_REQ  one-hot read response strobe
- `rsp_rdata`  out  DATA_WIDTH  read data; meaningful only while some `rsp_valid` bit is high
- `sram_we_a`  out  1  to scratchpad write enable
- `sram_addr_a`  out  ADDR_WIDTH  to scratchpad write address
- `sram_wdata_a`  out  DATA_WIDTH  to scratchpad write data
- `sram_re_b`  out  1  to scratchpad read enable
- `sram_addr_b`  out  ADDR_WIDTH  to scratchpad read address
- `sram_rdata_b`  in  DATA_WIDTH  from scratchpad; valid the cycle after `sram_re_b`

## Operation
- Write arbiter candidates: `req_valid[i] & req_we[i]`. Read arbiter candidates: `req_valid[i] & ~req_we[i]`.
- Round-robin per arbiter. Each arbiter has a pointer `ptr`. Priority is `ptr, ptr+1, …` modulo NUM_REQ. After a grant to requester g, `ptr <= (g+1) % NUM_REQ`. With no grant, `ptr` holds. Reset value of `ptr` is 0.
- Grants are combinational from the current inputs and `ptr`. `sram_we_a` = any write granted; address and data are muxed from the winner. Read port behaves the same way. When idle, the mux outputs are 0.
- Hazard: if this cycle's read winner's address equals this cycle's write winner's address, the read grant is suppressed.
  - `sram_re_b` = 0 and the read `ptr` holds.
  - The read is granted the next cycle, when the write has landed.
- A requester never has both write and read ready in the same cycle, because `req_we` selects only one arbiter.
- Requesters hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until accepted.
- Response path:
  - Registered one-hot `rd_owner` <= read grant vector.
  - `rsp_valid = rd_owner`.
  - `rsp_rdata = sram_rdata_b` (pass-through).
  - There is no response backpressure; requesters must sink `rsp_valid`.

## Timing
- Write accepted in cycle T: data is in the SRAM at the edge ending T. A read accepted in T+1 sees it.
- Read accepted in cycle T: `rsp_valid`/`rsp_rdata` are valid in T+1. Fixed 1-cycle latency. Throughput is 1 read plus 1 write per cycle.
- Fairness: with all requesters contending on one port, each is granted at least once every NUM_REQ grants on that port. A hazard adds at most 1 cycle per read.
- Reset (`rst_n` = 0 at a clock edge):
  - `ptr`s go to 0 and `rd_owner` goes to 0, so `rsp_valid` = 0 in the next cycle.
  - While `rst_n` is low, `req_ready`, `sram_we_a` and `sram_re_b` are forced to 0.
  - A read granted in the cycle before reset asserts loses its response. Requesters must reissue it.
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `sram_we_a` = 0, `sram_re_b` = 0, addresses and data = 0.

## Structure
- Shared package `scratchpad_pkg` holds:
  - default `DATA_WIDTH`/`ADDR_WIDTH`
  - `MAX_REQ` = 8
  - a `clog2` helper for requester-id width
- Sub-module `rr_arbiter`: `clk`, `rst_n`, `req[N]`, `gnt[N]` one-hot, `advance` input. `advance` gates the pointer update, so a read suppressed by a hazard does not advance the pointer.
- `rr_arbiter` is instantiated twice: write and read.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with all `req_valid` = 1. Check `req_ready` = 0, `sram_we_a` = `sram_re_b` = 0, and `rsp_valid` = 0 the cycle after release.
- Write-then-read: req0 writes 0xDEADBEEF to addr 0x005 in T. req1 reads 0x005 in T+1. Check `rsp_valid` = 2'b10 in T+2 with `rsp_rdata` = 0xDEADBEEF.
- Round-robin: both requesters issue back-to-back reads of addrs 0x010/0x020 for 6 cycles. Check grants alternate 0,1,0,1,… and responses match the owners one cycle later.
- Concurrent ports: req0 writes 0x111 to 0x030 while req1 reads 0x040 in the same cycle. Check both granted, `sram_we_a` = `sram_re_b` = 1, and req1's response in T+1.
- Hazard: req0 writes 0xA5A5A5A5 to 0x07F and req1 reads 0x07F in the same cycle T. Check the read is not ready in T and is granted in T+1. Check `rsp_rdata` = 0xA5A5A5A5 in T+2.
- Reset mid-read: read granted in T, `rst_n` = 0 in T+1. Check `rsp_valid` = 0 in T+1 and T+2, and both `ptr`s restart at requester 0.
